// File: rtl/rotor_pkg.sv
// Shared definitions for the rotor step driver: FSM state encoding, default
// timing constants and the signed-angle magnitude helper.
package rotor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_STEP_HI = 3'd1,
        ST_STEP_LO = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_DONE    = 3'd4
    } rotor_state_t;

    localparam int DEF_STEP_HIGH_CYC   = 4;
    localparam int DEF_STEP_PERIOD_CYC = 16;
    localparam int DEF_SETTLE_CYC      = 8;

    // Phase timer width; comfortably covers any realistic phase length.
    localparam int TIMER_W = 16;

    // Unsigned magnitude of a two's-complement step count. -128 maps to 128,
    // which still fits in 8 unsigned bits.
    function automatic logic [7:0] angle_mag(input logic [7:0] a);
        return a[7] ? (~a + 8'd1) : a;
    endfunction

endpackage

// File: rtl/rotor_step_driver_if.sv
// Command/status bundle between the angle lookup stage and the step driver.
//   master : issues commands (angle_valid, angle), observes driver outputs
//   slave  : the driver; returns angle_ready, step, dir, enable, busy, done,
//            position
interface rotor_step_driver_if;
    logic       angle_valid;
    logic [7:0] angle;
    logic       angle_ready;
    logic       step;
    logic       dir;
    logic       enable;
    logic       busy;
    logic       done;
    logic [7:0] position;

    modport master (
        output angle_valid, angle,
        input  angle_ready, step, dir, enable, busy, done, position
    );

    modport slave (
        input  angle_valid, angle,
        output angle_ready, step, dir, enable, busy, done, position
    );
endinterface

// File: rtl/rotor_timer.sv
// Loadable down-counter with zero flag; times every FSM phase.
//   clk, rst  : clock, async active-high reset
//   load      : load load_val this cycle (has priority over counting)
//   load_val  : value loaded; a phase of L cycles is loaded with L-1
//   zero      : counter is at zero (phase ends this cycle)
// Once at zero the counter holds until reloaded.
module rotor_timer
    import rotor_pkg::*;
#(
    parameter int W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rotor_step_driver.sv
// Stepper rotor driver: accepts a signed step count, emits that many step
// pulses in the commanded direction, holds the coils energised to settle,
// then pulses done. Tracks accumulated position modulo 256.
//   clk, rst : clock, async active-high reset
//   abort    : (only with ROTOR_ABORT_EN defined) stop stepping, go settle
//   bus      : slave side of rotor_step_driver_if (command in, status out)
// All outputs are registered; step comes straight from a flop.
// Parameters must satisfy STEP_PERIOD_CYC > STEP_HIGH_CYC >= 1, SETTLE_CYC >= 1.
module rotor_step_driver
    import rotor_pkg::*;
#(
    parameter int STEP_HIGH_CYC   = DEF_STEP_HIGH_CYC,
    parameter int STEP_PERIOD_CYC = DEF_STEP_PERIOD_CYC,
    parameter int SETTLE_CYC      = DEF_SETTLE_CYC
) (
    input  logic                clk,
    input  logic                rst,
`ifdef ROTOR_ABORT_EN
    input  logic                abort,
`endif
    rotor_step_driver_if.slave  bus
);

    // Timer reload values: a phase of L cycles counts L-1 down to 0.
    localparam logic [TIMER_W-1:0] HI_LOAD     = TIMER_W'(STEP_HIGH_CYC - 1);
    localparam logic [TIMER_W-1:0] LO_LOAD     = TIMER_W'(STEP_PERIOD_CYC - STEP_HIGH_CYC - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYC - 1);

    rotor_state_t       state;
    logic [7:0]         rem;        // steps left, including the one in flight
    logic [7:0]         mag;
    logic               accept;
    logic               last_step;
    logic               abort_i;
    logic               t_load;
    logic [TIMER_W-1:0] t_val;
    logic               t_zero;

    logic               step_r;
    logic               dir_r;
    logic               enable_r;
    logic               busy_r;
    logic               done_r;
    logic               ready_r;
    logic [7:0]         pos_r;

`ifdef ROTOR_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    assign mag       = angle_mag(bus.angle);
    assign accept    = bus.angle_valid && ready_r;
    assign last_step = (rem == 8'd1);

    // Phase timer reloads happen on the same edge as the state change they
    // time, so the timer always describes the state being entered.
    always_comb begin
        t_load = 1'b0;
        t_val  = HI_LOAD;
        case (state)
            ST_IDLE: begin
                if (accept && mag != 8'd0) begin
                    t_load = 1'b1;
                    t_val  = HI_LOAD;
                end
            end
            ST_STEP_HI: begin
                if (abort_i) begin
                    t_load = 1'b1;
                    t_val  = SETTLE_LOAD;
                end else if (t_zero) begin
                    t_load = 1'b1;
                    t_val  = LO_LOAD;
                end
            end
            ST_STEP_LO: begin
                if (abort_i || (t_zero && last_step)) begin
                    t_load = 1'b1;
                    t_val  = SETTLE_LOAD;
                end else if (t_zero) begin
                    t_load = 1'b1;
                    t_val  = HI_LOAD;
                end
            end
            default: ;
        endcase
    end

    rotor_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .zero     (t_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            rem      <= 8'd0;
            step_r   <= 1'b0;
            dir_r    <= 1'b0;
            enable_r <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            ready_r  <= 1'b0;
            pos_r    <= 8'd0;
        end else begin
            done_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // ready stays low for the first cycle out of reset
                    ready_r <= 1'b1;
                    if (accept) begin
                        ready_r <= 1'b0;
                        dir_r   <= bus.angle[7];
                        if (mag == 8'd0) begin
                            state  <= ST_DONE;
                            done_r <= 1'b1;
                        end else begin
                            state    <= ST_STEP_HI;
                            rem      <= mag;
                            step_r   <= 1'b1;
                            busy_r   <= 1'b1;
                            enable_r <= 1'b1;
                            // direction comes from the incoming angle; dir_r
                            // is only updated on this same edge
                            pos_r    <= bus.angle[7] ? pos_r - 8'd1 : pos_r + 8'd1;
                        end
                    end
                end
                ST_STEP_HI: begin
                    if (abort_i) begin
                        state  <= ST_SETTLE;
                        step_r <= 1'b0;
                    end else if (t_zero) begin
                        state  <= ST_STEP_LO;
                        step_r <= 1'b0;
                    end
                end
                ST_STEP_LO: begin
                    if (abort_i || (t_zero && last_step)) begin
                        state <= ST_SETTLE;
                    end else if (t_zero) begin
                        state  <= ST_STEP_HI;
                        rem    <= rem - 8'd1;
                        step_r <= 1'b1;
                        pos_r  <= dir_r ? pos_r - 8'd1 : pos_r + 8'd1;
                    end
                end
                ST_SETTLE: begin
                    if (t_zero) begin
                        state    <= ST_DONE;
                        busy_r   <= 1'b0;
                        enable_r <= 1'b0;
                        done_r   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.angle_ready = ready_r;
    assign bus.step        = step_r;
    assign bus.dir         = dir_r;
    assign bus.enable      = enable_r;
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.position    = pos_r;

endmodule

// File: tb/tb_rotor_step_driver.sv
// Bench for rotor_step_driver: a timeline model predicts every output from
// the cycle offset since acceptance; one negedge process compares each cycle
// and also evaluates queued literal checks from the directed sequence.
module tb_rotor_step_driver;

    localparam int H = 4;
    localparam int P = 16;
    localparam int S = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic abort = 1'b0;

    rotor_step_driver_if bus();

    rotor_step_driver dut (
        .clk   (clk),
        .rst   (rst),
`ifdef ROTOR_ABORT_EN
        .abort (abort),
`endif
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ---------------- model ----------------
    int  cyc = 0, t0 = 0, n = 0, settle_k = 0, base = 0, mk = 0, msteps = 0;
    bit  active = 0, m_dir = 0;
    bit  e_step = 0, e_dir = 0, e_en = 0, e_busy = 0, e_done = 0, e_ready = 0;
    int  e_pos = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            active = 0; base = 0; m_dir = 0; cyc = 0;
            e_step = 0; e_dir = 0; e_en = 0; e_busy = 0; e_done = 0; e_ready = 0; e_pos = 0;
        end else begin
            if (!active) begin
                if (e_ready && bus.angle_valid) begin
                    active   = 1;
                    t0       = cyc;
                    n        = bus.angle[7] ? 256 - int'(bus.angle) : int'(bus.angle);
                    m_dir    = bus.angle[7];
                    settle_k = n * P;
                end
            end else begin
                mk = cyc - t0;
                if (abort && n > 0 && mk >= 1 && mk <= settle_k) settle_k = mk;
            end
            cyc++;
            e_step = 0; e_done = 0;
            if (active) begin
                mk = cyc - t0;
                if (n == 0)             msteps = 0;
                else if (mk <= settle_k) msteps = (mk - 1) / P + 1;
                else                    msteps = (settle_k - 1) / P + 1;
                e_pos   = m_dir ? (base - msteps + 256) % 256 : (base + msteps) % 256;
                e_ready = 0;
                if (n > 0 && mk <= settle_k) begin
                    e_step = ((mk - 1) % P) < H;
                    e_busy = 1; e_en = 1;
                end else if (n > 0 && mk <= settle_k + S) begin
                    e_busy = 1; e_en = 1;
                end else if (mk == settle_k + (n > 0 ? S : 0) + 1) begin
                    e_busy = 0; e_en = 0; e_done = 1;
                end else begin
                    active = 0; base = e_pos; e_busy = 0; e_en = 0;
                end
            end
            if (!active) begin
                e_ready = 1;
                e_pos   = base;
            end
            e_dir = m_dir;
        end
    end

    // ---------------- compare ----------------
    typedef struct {
        string name;
        int    act;
        int    exp;
    } lit_t;

    lit_t lq[$];
    lit_t lc;
    int   tests = 0, fails = 0;
    int   ncyc = 0, acc_count = 0, acc_neg = 0, done_count = 0, done_neg = 0;
    int   pulse_cnt = 0, pos_at_done = 0;
    bit   step_q = 0;

    task automatic lit(input string name, input int act, input int exp);
        lit_t c;
        c.name = name; c.act = act; c.exp = exp;
        lq.push_back(c);
    endtask

    always @(negedge clk) begin
        ncyc++;
        tests++;
        if (bus.step !== e_step || bus.dir !== e_dir || bus.enable !== e_en ||
            bus.busy !== e_busy || bus.done !== e_done || bus.angle_ready !== e_ready ||
            int'(bus.position) != e_pos) begin
            fails++;
            $display("FAIL cycle %0d outputs: got step=%0b dir=%0b en=%0b busy=%0b done=%0b rdy=%0b pos=%0d, want step=%0b dir=%0b en=%0b busy=%0b done=%0b rdy=%0b pos=%0d",
                     ncyc, bus.step, bus.dir, bus.enable, bus.busy, bus.done, bus.angle_ready,
                     bus.position, e_step, e_dir, e_en, e_busy, e_done, e_ready, e_pos);
        end
        if (bus.angle_valid && bus.angle_ready) begin
            acc_count++;
            acc_neg = ncyc;
        end
        if (bus.done) begin
            done_count++;
            done_neg    = ncyc;
            pos_at_done = int'(bus.position);
        end
        if (bus.step && !step_q) pulse_cnt++;
        step_q = bus.step;
        while (lq.size() > 0) begin
            lc = lq.pop_front();
            tests++;
            if (lc.act != lc.exp) begin
                fails++;
                $display("FAIL %s: got %0d, want %0d", lc.name, lc.act, lc.exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_acc(input int tgt, input int budget);
        int k = 0;
        while (acc_count < tgt && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (acc_count < tgt) lit("accept_timeout", acc_count, tgt);
        #1;
    endtask

    task automatic send(input logic [7:0] a);
        @(posedge clk);
        #1;
        bus.angle_valid = 1'b1;
        bus.angle       = a;
        wait_acc(acc_count + 1, 50);
        bus.angle_valid = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int k = 0;
        while (done_count == d0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        if (done_count == d0) lit("done_timeout", done_count - d0, 1);
        #1;
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    int p0, d0, a1;

    initial begin
        bus.angle_valid = 1'b0;
        bus.angle       = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        lit("reset_pos", int'(bus.position), 0);
        lit("reset_ready", int'(bus.angle_ready), 0);
        lit("reset_enable", int'(bus.enable), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        lit("ready_after_reset", int'(bus.angle_ready), 1);

        // +3 steps
        p0 = pulse_cnt; d0 = done_count;
        send(8'h03);
        wait_done(d0, 200);
        lit("p3_pulses", pulse_cnt - p0, 3);
        lit("p3_pos", int'(bus.position), 3);
        lit("p3_dir", int'(bus.dir), 0);
        lit("p3_latency", done_neg - acc_neg, 57);
        lit("p3_dones", done_count - d0, 1);

        // -2 twice: 3 -> 1, then 1 -> 0 -> 255
        d0 = done_count;
        send(8'hFE);
        wait_done(d0, 200);
        lit("m2a_pos", int'(bus.position), 1);
        lit("m2a_latency", done_neg - acc_neg, 41);
        p0 = pulse_cnt; d0 = done_count;
        send(8'hFE);
        wait_done(d0, 200);
        lit("m2b_pos", int'(bus.position), 255);
        lit("m2b_dir", int'(bus.dir), 1);
        lit("m2b_pulses", pulse_cnt - p0, 2);
        @(posedge clk);
        #1;
        lit("m2b_dones", done_count - d0, 1);

        // zero-length command
        p0 = pulse_cnt; d0 = done_count;
        send(8'h00);
        wait_done(d0, 20);
        lit("z_latency", done_neg - acc_neg, 1);
        lit("z_pulses", pulse_cnt - p0, 0);
        lit("z_ready_next", int'(bus.angle_ready), 1);
        lit("z_pos", int'(bus.position), 255);

        // -128 from 0 with a second command held valid throughout
        pulse_rst();
        p0 = pulse_cnt;
        @(posedge clk);
        #1;
        bus.angle_valid = 1'b1;
        bus.angle       = 8'h80;
        wait_acc(acc_count + 1, 50);
        a1 = acc_neg;
        bus.angle = 8'h01;
        wait_acc(acc_count + 1, 3000);
        bus.angle_valid = 1'b0;
        lit("m128_second_accept_gap", acc_neg - a1, 128 * 16 + 8 + 2);
        lit("m128_pulses", pulse_cnt - p0, 128);
        lit("m128_pos_at_done", pos_at_done, 128);
        d0 = done_count;
        wait_done(d0, 100);
        lit("m128_then_p1_pos", int'(bus.position), 129);

        // reset in the 2nd STEP_HI of +5
        pulse_rst();
        p0 = pulse_cnt;
        send(8'h05);
        begin
            int k = 0;
            while (pulse_cnt < p0 + 2 && k < 100) begin
                @(posedge clk);
                k++;
            end
        end
        #1;
        lit("rst_mid_step_before", int'(bus.step), 1);
        rst = 1'b1;
        #1;
        lit("rst_mid_step", int'(bus.step), 0);
        lit("rst_mid_enable", int'(bus.enable), 0);
        lit("rst_mid_busy", int'(bus.busy), 0);
        lit("rst_mid_pos", int'(bus.position), 0);
        d0 = done_count;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        lit("rst_mid_no_done", done_count - d0, 0);
        lit("rst_mid_pos_after", int'(bus.position), 0);

`ifdef ROTOR_ABORT_EN
        // abort in the 2nd STEP_LO of +6
        p0 = pulse_cnt; d0 = done_count;
        send(8'h06);
        begin
            int k = 0;
            while (pulse_cnt < p0 + 2 && k < 100) begin
                @(posedge clk);
                k++;
            end
        end
        repeat (7) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_done(d0, 100);
        lit("abort_pulses", pulse_cnt - p0, 2);
        lit("abort_pos", int'(bus.position), 2);
        lit("abort_latency", done_neg - acc_neg, 25 + 8 + 1);
`endif

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rotor_step_driver.md
ROTOR_STEP_DRIVER -- requirements
Module: rotor_step_driver

Interface
REQ-001 SHALL provide parameter STEP_HIGH_CYC, default 4, clock cycles the step output is high per step.
REQ-002 SHALL provide parameter STEP_PERIOD_CYC, default 16, cycles per full step (high plus low); legal only if greater than STEP_HIGH_CYC.
REQ-003 SHALL provide parameter SETTLE_CYC, default 8, cycles to hold the rotor energised after the last step.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 angle_valid  input  1  angle command present.
REQ-007 angle  input  8  two's-complement signed step count produced by the angle lookup stage; sign gives direction.
REQ-008 angle_ready  output  1  driver can accept a command.
REQ-009 step  output  1  stepper pulse to the rotor driver.
REQ-010 dir  output  1  1 = negative rotation, 0 = positive.
REQ-011 enable  output  1  rotor coil enable.
REQ-012 busy  output  1  command in progress.
REQ-013 done  output  1  one-cycle pulse at command completion.
REQ-014 position  output  8  accumulated rotor position in steps, modulo 256.

Function
REQ-015 SHALL implement states IDLE, STEP_HI, STEP_LO, SETTLE and DONE.
REQ-016 SHALL drive angle_ready high only in IDLE; a command is accepted on a cycle with angle_valid and angle_ready both high.
REQ-017 On acceptance, SHALL latch the magnitude as 8-bit unsigned (-128 gives 128), latch dir from angle[7] and raise busy and enable on the next cycle.
REQ-018 If the accepted angle is 0, SHALL go IDLE -> DONE with no step pulse and no SETTLE.
REQ-019 For a nonzero magnitude, SHALL enter STEP_HI, hold step high for exactly STEP_HIGH_CYC cycles, then hold STEP_LO for STEP_PERIOD_CYC - STEP_HIGH_CYC cycles, and repeat per remaining step.
REQ-020 SHALL update position by +1 (dir=0) or -1 (dir=1) in the first cycle of each STEP_HI, wrapping 255->0 and 0->255.
REQ-021 After the final STEP_LO, SHALL hold SETTLE for SETTLE_CYC cycles with enable high and step low.
REQ-022 SHALL assert done for exactly one cycle in DONE, with busy and enable low in that cycle, then return to IDLE.
REQ-023 SHALL ignore angle_valid and angle while not in IDLE; angle and dir SHALL NOT change mid-command.
REQ-024 Latency from acceptance to done for magnitude N>0 SHALL be N*STEP_PERIOD_CYC + SETTLE_CYC + 1 cycles.
REQ-025 step SHALL be driven directly from a register (glitch-free).

Reset
REQ-026 While rst is high, SHALL force IDLE, step=0, dir=0, enable=0, busy=0, done=0, position=0 and angle_ready=0.
REQ-027 Reset asserted mid-command SHALL abort immediately, discard the remaining step count and leave position at 0.
REQ-028 angle_ready SHALL rise in the first cycle after rst deasserts.

Configuration
REQ-029 With macro ROTOR_ABORT_EN defined, SHALL add input abort (1 bit); abort high in STEP_HI or STEP_LO SHALL drop step, skip remaining steps and go to SETTLE next cycle; abort in IDLE, SETTLE or DONE SHALL be ignored; position keeps the steps actually issued.
REQ-030 Without ROTOR_ABORT_EN, SHALL have no abort port and every accepted command SHALL run to completion.

Structure
REQ-031 SHALL take the state encoding and the default timing constants from shared package rotor_pkg.
REQ-032 SHALL instantiate one sub-module rotor_timer (loadable down-counter with a zero flag) for all phase timing.

Verification
REQ-033 Reset then angle=8'h03 accepted -> 3 step pulses of 4 cycles high / 12 cycles low, dir=0, position=3, done 57 cycles after acceptance.
REQ-034 angle=8'hFE from position 1 -> dir=1, position goes 0 then 255, 2 pulses, one done pulse.
REQ-035 angle=8'h00 -> no step, done exactly 1 cycle after acceptance, angle_ready back high the following cycle.
REQ-036 angle=8'h80 -> 128 pulses, position=128; a second angle_valid held high throughout is not accepted until IDLE.
REQ-037 rst pulsed during the 2nd STEP_HI of angle=8'h05 -> step, enable and busy low immediately, position=0, no done pulse.
REQ-038 ROTOR_ABORT_EN defined: abort during the 2nd STEP_LO of angle=8'h06 -> no further pulses, position=2, SETTLE 8 cycles, then done.
